// File: rtl/seg_pkg.sv
// Shared constants for the scanned seven-segment bus: hex segment table,
// segment bit positions and digit count.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bit positions on the 8-bit bus
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high segment patterns for hex digits 0..F, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup of a 7-segment pattern to a hex nibble.
// Unknown patterns give valid=0 and nibble 0.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  // Search the hex table; the patterns are unique so at most one entry hits
  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/four_led_decoder.sv
// Receive side of a four-digit multiplexed seven-segment display: synchronises
// the scanned bus, accepts digits after a stable dwell, decodes them and
// assembles complete frames, discarding partial frames after a timeout.
module four_led_decoder
  import seg_pkg::*;
#(
  parameter int FREQUENCY_IN   = 50_000_000,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = FREQUENCY_IN / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  seg_cs_in,
  input  logic [7:0]  seg_data_in,
  output logic [15:0] bcd_out,
  output logic [3:0]  dot_out,
  output logic        err_out,
  output logic        frame_valid_out,
  output logic        timeout_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]  cs_m, cs_s;
  logic [7:0]  data_m, data_s;
  logic [11:0] prev;
  logic [7:0]  stab_cnt;
  logic        accepted;
  logic [15:0] slot_bcd;
  logic [3:0]  slot_dot;
  logic [3:0]  seen;
  logic        err_acc;
  logic        frame_pend;
  logic [TW-1:0] to_cnt;

  logic        same;
  logic        accept;
  logic        dec_valid;
  logic [3:0]  dec_nib;

  seg_pattern_decode u_decode (
    .seg    (data_s[6:0]),
    .valid  (dec_valid),
    .nibble (dec_nib)
  );

  assign same   = ({cs_s, data_s} == prev);
  assign accept = same && (stab_cnt == 8'(STABLE_CYCLES - 1)) && !accepted
                  && $onehot(cs_s);

  // Two-flop synchroniser on the whole scanned bus
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_m   <= '0;
      cs_s   <= '0;
      data_m <= '0;
      data_s <= '0;
    end else begin
      cs_m   <= seg_cs_in;
      cs_s   <= cs_m;
      data_m <= seg_data_in;
      data_s <= data_m;
    end
  end

  // Stability counter; accepted blocks a second accept within the same dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      stab_cnt <= '0;
      accepted <= 1'b0;
    end else begin
      prev <= {cs_s, data_s};
      if (same) begin
        if (stab_cnt != 8'(STABLE_CYCLES))
          stab_cnt <= stab_cnt + 8'd1;
        if (accept)
          accepted <= 1'b1;
      end else begin
        stab_cnt <= '0;
        accepted <= 1'b0;
      end
    end
  end

  // Latch the decoded digit and its dot into the selected slot
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_bcd <= '0;
      slot_dot <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cs_s[i]) begin
          slot_bcd[4*i +: 4] <= dec_nib;
          slot_dot[i]        <= data_s[SEG_DP];
        end
      end
    end
  end

  // Frame tracking: seen mask, sticky error, completion flag and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      seen        <= '0;
      err_acc     <= 1'b0;
      frame_pend  <= 1'b0;
      to_cnt      <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= 1'b0;
      frame_pend  <= 1'b0;
      if (accept) begin
        seen       <= seen | cs_s;
        err_acc    <= err_acc | ~dec_valid;
        to_cnt     <= '0;
        frame_pend <= ((seen | cs_s) == 4'hF);
      end else if (frame_pend) begin
        seen    <= '0;
        err_acc <= 1'b0;
        to_cnt  <= '0;
      end else if (seen != 4'h0) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_out <= 1'b1;
          seen        <= '0;
          err_acc     <= 1'b0;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // Publish a completed frame one cycle after its last accept
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out         <= '0;
      dot_out         <= '0;
      err_out         <= 1'b0;
      frame_valid_out <= 1'b0;
    end else begin
      frame_valid_out <= frame_pend;
      if (frame_pend) begin
        bcd_out <= slot_bcd;
        dot_out <= slot_dot;
        err_out <= err_acc;
      end
    end
  end

endmodule

// File: tb/tb_four_led_decoder.sv
// Directed bench for four_led_decoder: table of scanned frames plus hand
// sequences for timeout and mid-frame reset.
module tb_four_led_decoder;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 300;
  localparam int DWELL   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  seg_cs_in = '0;
  logic [7:0]  seg_data_in = '0;
  logic [15:0] bcd_out;
  logic [3:0]  dot_out;
  logic        err_out;
  logic        frame_valid_out;
  logic        timeout_out;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int to_cnt = 0;

  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dots;
    logic [3:0]  bad;
    logic        glitch;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_dot;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  four_led_decoder #(
    .FREQUENCY_IN  (50_000_000),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .seg_cs_in      (seg_cs_in),
    .seg_data_in    (seg_data_in),
    .bcd_out        (bcd_out),
    .dot_out        (dot_out),
    .err_out        (err_out),
    .frame_valid_out(frame_valid_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk = ~clk;

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (frame_valid_out) fv_cnt++;
    if (timeout_out) to_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_digit(input int idx, input logic [7:0] pat);
    @(negedge clk);
    seg_cs_in   = 4'(1 << idx);
    seg_data_in = pat;
    repeat (DWELL - 1) @(negedge clk);
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    seg_cs_in   = '0;
    seg_data_in = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_vector(input int k);
    int fv0, to0;
    logic [7:0] pat;
    fv0 = fv_cnt;
    to0 = to_cnt;
    for (int i = 0; i < 4; i++) begin
      if (vecs[k].glitch && i > 0) begin
        @(negedge clk);
        seg_cs_in   = 4'b0011;
        seg_data_in = 8'h00;
        repeat (4) @(negedge clk);
      end
      if (vecs[k].bad[i]) pat = {vecs[k].dots[i], 7'h2A};
      else                pat = {vecs[k].dots[i], seg_tbl[vecs[k].val[4*i +: 4]]};
      drive_digit(i, pat);
    end
    go_idle(6);
    check($sformatf("v%0d frames", k), 32'(fv_cnt - fv0), 32'd1);
    check($sformatf("v%0d timeouts", k), 32'(to_cnt - to0), 32'd0);
    check($sformatf("v%0d bcd", k), 32'(bcd_out), 32'(vecs[k].exp_bcd));
    check($sformatf("v%0d dot", k), 32'(dot_out), 32'(vecs[k].exp_dot));
    check($sformatf("v%0d err", k), 32'(err_out), 32'(vecs[k].exp_err));
  endtask

  initial begin
    int fv0, to0;
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{16'h1234, 4'b0100, 4'b0000, 1'b0, 16'h1234, 4'b0100, 1'b0};
    vecs[2] = '{16'h1234, 4'b0000, 4'b0000, 1'b1, 16'h1234, 4'b0000, 1'b0};
    vecs[3] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 16'h1230, 4'b0000, 1'b1};
    vecs[4] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 16'h1234, 4'b0000, 1'b0};
    vecs[5] = '{16'hCAFE, 4'b1111, 4'b0000, 1'b0, 16'hCAFE, 4'b1111, 1'b0};
    vecs[6] = '{16'h9E07, 4'b1010, 4'b0000, 1'b1, 16'h9E07, 4'b1010, 1'b0};
    vecs[7] = '{16'h8F5D, 4'b0011, 4'b0010, 1'b0, 16'h8F0D, 4'b0011, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset bcd", 32'(bcd_out), 32'h0);
    check("reset dot", 32'(dot_out), 32'h0);
    check("reset err", 32'(err_out), 32'h0);
    check("reset frame_valid", 32'(frame_valid_out), 32'h0);
    check("reset timeout", 32'(timeout_out), 32'h0);
    go_idle(40);
    check("idle no frame", 32'(fv_cnt), 32'd0);

    for (int k = 0; k < 8; k++) run_vector(k);

    // Partial frame then idle: one timeout, outputs keep last frame (8F0D)
    fv0 = fv_cnt;
    to0 = to_cnt;
    drive_digit(0, {1'b0, seg_tbl[9]});
    drive_digit(1, {1'b0, seg_tbl[9]});
    go_idle(TIMEOUT + 20);
    check("timeout pulses", 32'(to_cnt - to0), 32'd1);
    check("timeout no frame", 32'(fv_cnt - fv0), 32'd0);
    check("timeout bcd hold", 32'(bcd_out), 32'h8F0D);
    check("timeout dot hold", 32'(dot_out), 32'h3);
    check("timeout err hold", 32'(err_out), 32'h1);

    // Recovery after timeout
    run_vector(0);

    // Three digits (one bad), reset, then digit 3 alone must not complete
    drive_digit(0, {1'b0, 7'h2A});
    drive_digit(1, {1'b1, seg_tbl[1]});
    drive_digit(2, {1'b0, seg_tbl[1]});
    @(negedge clk);
    seg_cs_in   = '0;
    seg_data_in = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset bcd", 32'(bcd_out), 32'h0);
    check("midreset dot", 32'(dot_out), 32'h0);
    fv0 = fv_cnt;
    to0 = to_cnt;
    drive_digit(3, {1'b0, seg_tbl[5]});
    go_idle(10);
    check("midreset partial no frame", 32'(fv_cnt - fv0), 32'd0);
    drive_digit(0, {1'b0, seg_tbl[8]});
    drive_digit(1, {1'b0, seg_tbl[7]});
    drive_digit(2, {1'b0, seg_tbl[6]});
    go_idle(6);
    check("midreset frames", 32'(fv_cnt - fv0), 32'd1);
    check("midreset timeouts", 32'(to_cnt - to0), 32'd0);
    check("midreset bcd", 32'(bcd_out), 32'h5678);
    check("midreset dot", 32'(dot_out), 32'h0);
    check("midreset err", 32'(err_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
